spi_master_wide: RTL and testbench

SPI_MASTER_WIDE -- requirements
Module: spi_master_wide

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_halfper_tick.sv | 28 ++
 rtl/spi_master_wide.sv | 188 ++++++++++++++++++
 tb/tb_spi_master_wide.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the wide SPI master: controller state encoding and
// the chip-select index width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Chip-select index width: clog2 of the select count, never narrower than 1.
  function automatic int csw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period timebase: one-cycle tick every div_i+1 cycles while enabled;
// the count is held at zero while disabled so each enable starts a fresh period.
module spi_halfper_tick #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [DIVW-1:0] div_i,
  output logic            tick_o
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_wide.sv
// Parameterised SPI master (WIDTH bits, NCS selects, all four modes).
// Optional LSB-first support is enabled by defining SPI_MASTER_LSB_FIRST_EN.
module spi_master_wide
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCS   = 1,
  parameter int DIVW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIVW-1:0]       div,
  input  logic [csw(NCS)-1:0]   cs_sel,
  input  logic [WIDTH-1:0]      din,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      dout,
  output logic                  mclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NCS-1:0]        csn
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic                  lsb_first
`endif
);

  localparam int CSW = csw(NCS);
  localparam int HPW = $clog2(2 * WIDTH);
  localparam logic [HPW-1:0] HP_LAST = HPW'(2 * WIDTH - 1);

  spi_state_e       state_q, state_d;
  logic [HPW-1:0]   hp_q, hp_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [CSW-1:0]   cs_q, cs_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsb_q, lsb_d;

  logic             lsb_in;
  logic             tick;
  logic [HPW-1:0]   nxt_idx;
  logic             edge_ev, sample_ev, shift_ev;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  spi_halfper_tick #(.DIVW(DIVW)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != ST_IDLE),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    div_d     = div_q;
    cs_d      = cs_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;

    // An mclk edge happens when a tick opens XFER half-period nxt_idx;
    // even indices are leading edges.
    nxt_idx   = (state_q == ST_SETUP) ? '0 : hp_q + 1'b1;
    edge_ev   = tick && ((state_q == ST_SETUP) ||
                         ((state_q == ST_XFER) && (hp_q != HP_LAST)));
    sample_ev = edge_ev && (~nxt_idx[0] ^ cpha_q);
    shift_ev  = edge_ev && !sample_ev;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          div_d   = div;
          cs_d    = cs_sel;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_in;
          rx_d    = '0;
          // Mode with cpha=0 must have the first bit valid before the first edge.
          mosi_d  = cpha ? 1'b0 : pick_bit(din, lsb_in);
          tx_d    = cpha ? din  : advance(din, lsb_in);
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_XFER;
          hp_d    = '0;
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (hp_q == HP_LAST) state_d = ST_HOLD;
          else                 hp_d    = hp_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          dout_d  = rx_q;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sample_ev) rx_d = lsb_q ? {miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], miso};
    if (shift_ev) begin
      mosi_d = pick_bit(tx_q, lsb_q);
      tx_d   = advance(tx_q, lsb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hp_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      div_q   <= div_d;
      cs_q    <= cs_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign dout = dout_q;
  assign mosi = mosi_q;

  always_comb begin
    mclk = cpol_q;
    if (state_q == ST_IDLE)      mclk = cpol;
    else if (state_q == ST_XFER) mclk = cpol_q ^ ~hp_q[0];
  end

  // Out-of-range selects match no index, so every csn bit stays high.
  for (genvar gi = 0; gi < NCS; gi++) begin : g_csn
    assign csn[gi] = !(busy && (int'(cs_q) == gi));
  end

endmodule

// File: tb/tb_spi_master_wide.sv
// Directed bench: an 8-bit/4-select master and a 16-bit/3-select master
// sharing clock, reset and mode inputs.
module tb_spi_master_wide;

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, lsb;
  logic [7:0] div;

  logic       start_a, busy_a, done_a, mclk_a, mosi_a, miso_a, loop_a, miso_val_a;
  logic [1:0] cs_a;
  logic [7:0] din_a, dout_a;
  logic [3:0] csn_a;

  logic        start_b, busy_b, done_b, mclk_b, mosi_b, miso_b;
  logic [1:0]  cs_b;
  logic [15:0] din_b, dout_b;
  logic [2:0]  csn_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign miso_a = loop_a ? mosi_a : miso_val_a;

  spi_master_wide #(.WIDTH(8), .NCS(4), .DIVW(8)) dut_a (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .div(div), .cs_sel(cs_a),
    .din(din_a), .start(start_a), .busy(busy_a), .done(done_a), .dout(dout_a),
    .mclk(mclk_a), .mosi(mosi_a), .miso(miso_a), .csn(csn_a)
`ifdef SPI_MASTER_LSB_FIRST_EN
    , .lsb_first(lsb)
`endif
  );

  spi_master_wide #(.WIDTH(16), .NCS(3), .DIVW(8)) dut_b (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .div(div), .cs_sel(cs_b),
    .din(din_b), .start(start_b), .busy(busy_b), .done(done_b), .dout(dout_b),
    .mclk(mclk_b), .mosi(mosi_b), .miso(miso_b), .csn(csn_b)
`ifdef SPI_MASTER_LSB_FIRST_EN
    , .lsb_first(lsb)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer on dut_a and returns in its first idle cycle.
  task automatic run_a(input logic [7:0] d, output int n, output int dones);
    din_a = d; start_a = 1'b1; step(); start_a = 1'b0;
    n = 0; dones = 0;
    while (busy_a && n < 400) begin
      if (done_a) dones++;
      n++; step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; cpol = 1'b1;
    step(); step();
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_cmp++; if (csn_a !== 4'hF) begin n_bad++; $display("FAIL reset_csn: got %h want f", csn_a); end
    n_cmp++; if (mosi_a !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
    n_cmp++; if (dout_a !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout_a); end
    n_cmp++; if (mclk_b !== 1'b1) begin n_bad++; $display("FAIL reset_mclk_hi: got %b want 1", mclk_b); end
    cpol = 1'b0; #1;
    n_cmp++; if (mclk_a !== 1'b0) begin n_bad++; $display("FAIL reset_mclk_lo: got %b want 0", mclk_a); end
    start_a = 1'b0; start_b = 1'b0; step(); rst = 1'b0; step();
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored: got %b want 0", busy_a); end
    $display("reset: busy=%b csn=%h dout=%h", busy_a, csn_a, dout_a);
  endtask

  task automatic test_mode0();
    int n, dones;
    logic [7:0] cap;
    cpol = 0; cpha = 0; div = 0; cs_a = 0; loop_a = 1;
    din_a = 8'hA5; start_a = 1'b1; step(); start_a = 1'b0;
    n = 0; dones = 0; cap = '0;
    while (busy_a && n < 400) begin
      if ((n % 2 == 1) && n <= 15) cap[7 - (n - 1) / 2] = mosi_a;
      if (done_a) dones++;
      n++; step();
    end
    n_cmp++; if (n != 18) begin n_bad++; $display("FAIL mode0_busy_len: got %0d want 18", n); end
    n_cmp++; if (done_a !== 1'b1 || dones != 0) begin n_bad++; $display("FAIL mode0_done: got %b/%0d want 1/0", done_a, dones); end
    n_cmp++; if (dout_a !== 8'hA5) begin n_bad++; $display("FAIL mode0_dout: got %h want a5", dout_a); end
    n_cmp++; if (cap !== 8'hA5) begin n_bad++; $display("FAIL mode0_mosi_bits: got %h want a5", cap); end
    step();
    n_cmp++; if (done_a !== 1'b0 || mosi_a !== 1'b0 || mclk_a !== 1'b0) begin
      n_bad++; $display("FAIL mode0_after: got done=%b mosi=%b mclk=%b want 0/0/0", done_a, mosi_a, mclk_a); end
    $display("mode0: busy=%0d dout=%h mosi_bits=%h", n, dout_a, cap);
  endtask

  task automatic test_mode1();
    int n, dones;
    cpol = 0; cpha = 1; div = 2; cs_a = 1; loop_a = 1;
    run_a(8'h96, n, dones);
    n_cmp++; if (n != 54) begin n_bad++; $display("FAIL mode1_busy_len: got %0d want 54", n); end
    n_cmp++; if (dout_a !== 8'h96) begin n_bad++; $display("FAIL mode1_dout: got %h want 96", dout_a); end
    $display("mode1: busy=%0d dout=%h", n, dout_a);
    step();
  endtask

  task automatic test_mode3();
    int n, toggles, last, first, badgap;
    logic prev;
    cpol = 1; cpha = 1; div = 3; cs_b = 0; miso_b = 1'b1;
    step();
    n_cmp++; if (mclk_b !== 1'b1) begin n_bad++; $display("FAIL mode3_idle_pre: got %b want 1", mclk_b); end
    din_b = 16'h1234; start_b = 1'b1; step(); start_b = 1'b0;
    n = 0; toggles = 0; last = 0; first = -1; badgap = 0; prev = 1'b1;
    while (busy_b && n < 1000) begin
      if (mclk_b !== prev) begin
        toggles++;
        if (first < 0) first = n;
        else if (n - last != 4) badgap++;
        last = n;
      end
      prev = mclk_b;
      n++; step();
    end
    n_cmp++; if (n != 136) begin n_bad++; $display("FAIL mode3_busy_len: got %0d want 136", n); end
    n_cmp++; if (toggles != 32) begin n_bad++; $display("FAIL mode3_edges: got %0d want 32", toggles); end
    n_cmp++; if (first != 4 || badgap != 0) begin n_bad++; $display("FAIL mode3_halfper: got first=%0d badgaps=%0d want 4/0", first, badgap); end
    n_cmp++; if (dout_b !== 16'hFFFF || done_b !== 1'b1) begin n_bad++; $display("FAIL mode3_dout: got %h done=%b want ffff/1", dout_b, done_b); end
    step();
    n_cmp++; if (mclk_b !== 1'b1) begin n_bad++; $display("FAIL mode3_idle_post: got %b want 1", mclk_b); end
    $display("mode3: busy=%0d edges=%0d dout=%h", n, toggles, dout_b);
  endtask

  task automatic test_cs_select();
    int n, bad;
    cpol = 0; cpha = 0; div = 1; cs_a = 2; loop_a = 1;
    n_cmp++; if (csn_a !== 4'hF) begin n_bad++; $display("FAIL cs_pre: got %h want f", csn_a); end
    din_a = 8'h5A; start_a = 1'b1; step(); start_a = 1'b0;
    n = 0; bad = 0;
    while (busy_a && n < 400) begin
      if (csn_a !== 4'b1011) bad++;
      n++; step();
    end
    n_cmp++; if (n != 36 || bad != 0) begin n_bad++; $display("FAIL cs_sel2: got len=%0d bad=%0d want 36/0", n, bad); end
    n_cmp++; if (csn_a !== 4'hF) begin n_bad++; $display("FAIL cs_post: got %h want f", csn_a); end
    $display("cs_select: len=%0d badcycles=%0d", n, bad);
    step();
  endtask

  task automatic test_cs_out_of_range();
    int n, bad;
    cpol = 0; cpha = 0; div = 0; cs_b = 2'd3; miso_b = 1'b0;
    din_b = 16'hBEEF; start_b = 1'b1; step(); start_b = 1'b0;
    n = 0; bad = 0;
    while (busy_b && n < 400) begin
      if (csn_b !== 3'b111) bad++;
      n++; step();
    end
    n_cmp++; if (n != 34 || bad != 0 || done_b !== 1'b1) begin
      n_bad++; $display("FAIL cs_oob: got len=%0d bad=%0d done=%b want 34/0/1", n, bad, done_b); end
    $display("cs_out_of_range: len=%0d badcycles=%0d", n, bad);
    step();
  endtask

  task automatic test_ignore_start();
    int n, dones;
    cpol = 0; cpha = 0; div = 0; cs_a = 0; loop_a = 1;
    din_a = 8'h3C; start_a = 1'b1; step(); start_a = 1'b0;
    n = 0; dones = 0;
    while (busy_a && n < 400) begin
      if (n == 5) begin din_a = 8'hFF; div = 8'd5; start_a = 1'b1; end
      if (n == 6) start_a = 1'b0;
      if (done_a) dones++;
      n++; step();
    end
    n_cmp++; if (n != 18) begin n_bad++; $display("FAIL ignore_len: got %0d want 18", n); end
    n_cmp++; if (dout_a !== 8'h3C) begin n_bad++; $display("FAIL ignore_dout: got %h want 3c", dout_a); end
    div = 0; step();
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL ignore_no_restart: got %b want 0", busy_a); end
    $display("ignore_start: len=%0d dout=%h", n, dout_a);
  endtask

  task automatic test_reset_abort();
    int n, dones;
    cpol = 0; cpha = 0; div = 0; cs_a = 1; loop_a = 0; miso_val_a = 1'b0;
    run_a(8'h5A, n, dones);
    n_cmp++; if (dout_a !== 8'h00) begin n_bad++; $display("FAIL abort_pre_dout: got %h want 00", dout_a); end
    step();
    miso_val_a = 1'b1;
    din_a = 8'h77; start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (csn_a !== 4'hF || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL abort_csn: got csn=%h busy=%b want f/0", csn_a, busy_a); end
    dones = 0;
    for (int i = 0; i < 20; i++) begin if (done_a) dones++; step(); end
    n_cmp++; if (dones != 0 || dout_a !== 8'h00) begin
      n_bad++; $display("FAIL abort_no_done: got dones=%0d dout=%h want 0/00", dones, dout_a); end
    loop_a = 1;
    run_a(8'hC3, n, dones);
    n_cmp++; if (n != 18 || dout_a !== 8'hC3) begin
      n_bad++; $display("FAIL abort_recover: got len=%0d dout=%h want 18/c3", n, dout_a); end
    $display("reset_abort: recovery len=%0d dout=%h", n, dout_a);
    step();
  endtask

  task automatic test_back_to_back();
    int n, dones;
    cpol = 0; cpha = 0; div = 0; cs_a = 3; loop_a = 1;
    run_a(8'h81, n, dones);
    n_cmp++; if (done_a !== 1'b1 || dout_a !== 8'h81) begin
      n_bad++; $display("FAIL b2b_first: got done=%b dout=%h want 1/81", done_a, dout_a); end
    din_a = 8'h7E; start_a = 1'b1; step(); start_a = 1'b0;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %b want 1", busy_a); end
    n = 0;
    while (busy_a && n < 400) begin n++; step(); end
    n_cmp++; if (n != 18 || dout_a !== 8'h7E) begin
      n_bad++; $display("FAIL b2b_second: got len=%0d dout=%h want 18/7e", n, dout_a); end
    $display("back_to_back: second len=%0d dout=%h", n, dout_a);
    step();
  endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
  task automatic test_lsb_first();
    int n;
    logic [7:0] cap;
    cpol = 0; cpha = 0; div = 0; cs_a = 0; loop_a = 1; lsb = 1'b1;
    din_a = 8'h01; start_a = 1'b1; step(); start_a = 1'b0; lsb = 1'b0;
    n = 0; cap = '0;
    while (busy_a && n < 400) begin
      if ((n % 2 == 1) && n <= 15) cap[(n - 1) / 2] = mosi_a;
      n++; step();
    end
    n_cmp++; if (cap !== 8'h01) begin n_bad++; $display("FAIL lsb_mosi: got %h want 01", cap); end
    n_cmp++; if (dout_a !== 8'h01) begin n_bad++; $display("FAIL lsb_dout: got %h want 01", dout_a); end
    $display("lsb_first: mosi_bits=%h dout=%h", cap, dout_a);
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; cpol = 0; cpha = 0; lsb = 0; div = 0;
    start_a = 0; cs_a = 0; din_a = 0; loop_a = 1; miso_val_a = 0;
    start_b = 0; cs_b = 0; din_b = 0; miso_b = 0;
    test_reset();
    test_mode0();
    test_mode1();
    test_mode3();
    test_cs_select();
    test_cs_out_of_range();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SPI_MASTER_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
